xor_memory: RTL and testbench



---
 rtl/xor_memory.sv | 101 ++++++++++
 tb/tb_xor_memory.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/xor_memory.sv
// Multi-port scratch RAM built from single-writer banks combined by XOR; every port may read and write each cycle.
// Optional write-first forwarding when XOR_MEMORY_BYPASS_EN is defined (default build is read-first).
module xor_memory #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 256,
  parameter int PORTS = 2,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [AW-1:0]    addr [PORTS],
  input  logic [WIDTH-1:0] d    [PORTS],
  input  logic [PORTS-1:0] en,
  output logic [WIDTH-1:0] q    [PORTS]
);

  localparam logic [AW:0] DEPTH_W = DEPTH[AW:0];

  // bank[w][r]: written only by port w, read only by port r
  logic [WIDTH-1:0] bank [PORTS][PORTS][DEPTH];

  logic [PORTS-1:0] in_range;
  logic [PORTS-1:0] wr_go;
  logic [WIDTH-1:0] wr_val [PORTS];
  logic [WIDTH-1:0] rd_val [PORTS];

  always_comb begin
    for (int p = 0; p < PORTS; p++) begin
      in_range[p] = ({1'b0, addr[p]} < DEPTH_W);
    end
  end

  // Lowest-indexed enabled port wins a same-address collision.
  always_comb begin
    for (int w = 0; w < PORTS; w++) begin
      wr_go[w] = en[w] & in_range[w];
      for (int k = 0; k < PORTS; k++) begin
        if (k < w && en[k] && in_range[k] && addr[k] == addr[w]) begin
          wr_go[w] = 1'b0;
        end
      end
    end
  end

  // Cancel the other writers' contributions so the XOR of all groups yields d.
  always_comb begin
    for (int w = 0; w < PORTS; w++) begin
      wr_val[w] = d[w];
      for (int k = 0; k < PORTS; k++) begin
        if (k != w) begin
          wr_val[w] = wr_val[w] ^ bank[k][w][addr[w]];
        end
      end
    end
  end

  always_comb begin
    for (int p = 0; p < PORTS; p++) begin
      rd_val[p] = '0;
      if (in_range[p]) begin
        for (int w = 0; w < PORTS; w++) begin
          rd_val[p] = rd_val[p] ^ bank[w][p][addr[p]];
        end
      end
`ifdef XOR_MEMORY_BYPASS_EN
      for (int w = PORTS - 1; w >= 0; w--) begin
        if (wr_go[w] && addr[w] == addr[p]) begin
          rd_val[p] = d[w];
        end
      end
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int w = 0; w < PORTS; w++) begin
        for (int r = 0; r < PORTS; r++) begin
          for (int a = 0; a < DEPTH; a++) begin
            bank[w][r][a] <= '0;
          end
        end
      end
      for (int p = 0; p < PORTS; p++) begin
        q[p] <= '0;
      end
    end else begin
      for (int w = 0; w < PORTS; w++) begin
        if (wr_go[w]) begin
          for (int r = 0; r < PORTS; r++) begin
            bank[w][r][addr[w]] <= wr_val[w];
          end
        end
      end
      for (int p = 0; p < PORTS; p++) begin
        q[p] <= rd_val[p];
      end
    end
  end

endmodule

// File: tb/tb_xor_memory.sv
// Scoreboard bench for xor_memory: driver models a plain array memory and queues expected q values; a monitor checks them.
module tb_xor_memory;
  localparam int W  = 8;
  localparam int D  = 256;
  localparam int P  = 2;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] addr [P];
  logic [W-1:0]  d    [P];
  logic [P-1:0]  en;
  logic [W-1:0]  q    [P];

  always #5 clk = ~clk;

  xor_memory #(.WIDTH(W), .DEPTH(D), .PORTS(P)) dut (
    .clk(clk), .rst(rst), .addr(addr), .d(d), .en(en), .q(q)
  );

  typedef struct {
    int         port;
    logic [W-1:0] val;
    string      tag;
  } exp_t;

  exp_t         sb [$];
  logic [W-1:0] mem [D];
  int           errors = 0;
  int           checks = 0;

  task automatic clear_model();
    for (int a = 0; a < D; a++) mem[a] = '0;
  endtask

  // Drive one cycle (called just after a negedge), queue expected reads, update the model.
  task automatic cycle(input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                       input logic [W-1:0] d0, input logic [W-1:0] d1,
                       input logic [P-1:0] e, input string tag);
    logic [AW-1:0] aa [P];
    logic [W-1:0]  dd [P];
    exp_t          x;
    aa[0] = a0; aa[1] = a1; dd[0] = d0; dd[1] = d1;
    for (int p = 0; p < P; p++) begin
      addr[p] = aa[p];
      d[p]    = dd[p];
    end
    en = e;
    for (int p = 0; p < P; p++) begin
      x.port = p;
      x.tag  = tag;
      x.val  = mem[aa[p]];
`ifdef XOR_MEMORY_BYPASS_EN
      for (int w = P - 1; w >= 0; w--) begin
        if (e[w] && aa[w] == aa[p]) x.val = dd[w];
      end
`endif
      sb.push_back(x);
    end
    // Apply highest port first so the lowest-indexed writer ends up holding the word.
    for (int w = P - 1; w >= 0; w--) begin
      if (e[w]) mem[aa[w]] = dd[w];
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_now(input string tag, input logic [W-1:0] got, input logic [W-1:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      while (sb.size() > 0) begin
        e = sb.pop_front();
        checks++;
        if (q[e.port] !== e.val) begin
          errors++;
          $display("FAIL %s q[%0d]: got %h expected %h", e.tag, e.port, q[e.port], e.val);
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    en  = '0;
    for (int p = 0; p < P; p++) begin
      addr[p] = '0;
      d[p]    = '0;
    end
    clear_model();
    #1;
    check_now("reset_q0", q[0], 8'h00);
    check_now("reset_q1", q[1], 8'h00);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    cycle(8'd5, 8'd0, 8'd42, 8'h00, 2'b01, "xport_wr");
    cycle(8'd0, 8'd0, 8'h00, 8'h00, 2'b00, "idle");
    cycle(8'd0, 8'd5, 8'h00, 8'h00, 2'b00, "xport_rd");

    cycle(8'd3, 8'd7, 8'h11, 8'h22, 2'b11, "par_wr");
    cycle(8'd7, 8'd3, 8'h00, 8'h00, 2'b00, "par_rd");

    cycle(8'd9, 8'd0, 8'hAA, 8'h00, 2'b01, "ovw_p0");
    cycle(8'd0, 8'd9, 8'h00, 8'h55, 2'b10, "ovw_p1");
    cycle(8'd9, 8'd9, 8'h00, 8'h00, 2'b00, "ovw_rd");

    cycle(8'd12, 8'd12, 8'h0F, 8'hF0, 2'b11, "collide");
    cycle(8'd12, 8'd12, 8'h00, 8'h00, 2'b00, "collide_rd");

    cycle(8'd20, 8'd0, 8'h01, 8'h00, 2'b01, "rdw_init");
    cycle(8'd20, 8'd20, 8'h02, 8'h00, 2'b01, "rdw");
    cycle(8'd20, 8'd20, 8'h00, 8'h00, 2'b00, "rdw_after");
    cycle(8'd30, 8'd30, 8'h00, 8'h66, 2'b10, "rdw_p1wr");
    cycle(8'd30, 8'd30, 8'h00, 8'h00, 2'b00, "rdw_p1after");

    cycle(8'd1, 8'd0, 8'h77, 8'h00, 2'b01, "rst_pre_wr");
    cycle(8'd1, 8'd1, 8'h00, 8'h00, 2'b00, "rst_pre_rd");
    #1 rst = 1'b1;
    #1;
    check_now("async_rst_q0", q[0], 8'h00);
    check_now("async_rst_q1", q[1], 8'h00);
    #1 rst = 1'b0;
    clear_model();
    cycle(8'd1, 8'd1, 8'h00, 8'h00, 2'b00, "post_rst_rd");

    // A write presented while reset spans an edge must be discarded.
    addr[0] = 8'd2; d[0] = 8'h33; en = 2'b01;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    en  = '0;
    cycle(8'd2, 8'd2, 8'h00, 8'h00, 2'b00, "rst_edge_wr");

    for (int i = 0; i < 400; i++) begin
      cycle(8'($urandom_range(15)), 8'($urandom_range(15)),
            8'($urandom), 8'($urandom), 2'($urandom_range(3)), "random");
    end

    @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
